// File: rtl/button_cond_pkg.sv
// Shared types and constants for the push-button conditioner.
// Channel indices let the top level wire buttons to the alarm-clock core by name.
package button_cond_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } btn_state_t;

  localparam int BTN_MIN  = 0;
  localparam int BTN_HRS  = 1;
  localparam int BTN_TSET = 2;
  localparam int BTN_ASET = 3;

  localparam int ACCEL_CNT_W = 4;

  // Counter width able to hold the value n.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchronizer, debounce counter, press/auto-repeat FSM with registered strobe.
// With BUTTON_COND_ACCEL_EN the repeat period halves after ACCEL_AFTER repeat strobes.
module btn_channel
  import button_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
`ifdef BUTTON_COND_ACCEL_EN
  ,
  parameter int ACCEL_AFTER   = 8
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic adv_o
);

  localparam int DB_W    = cnt_w(DEBOUNCE_CYC);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_w(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  btn_state_t       state_q;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] reload;
  logic             adv_q;
  logic             rise, fall, expire;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rise   = level_d & ~level_q;
  assign fall   = ~level_d & level_q;
  assign expire = (state_q != IDLE) && (rpt_cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b00;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

`ifdef BUTTON_COND_ACCEL_EN
  localparam int FAST_PERIOD = (REPEAT_PERIOD / 2 > 1) ? REPEAT_PERIOD / 2 : 1;
  localparam logic [RPT_W-1:0] FAST_LOAD = RPT_W'(FAST_PERIOD - 1);

  logic [ACCEL_CNT_W-1:0] accel_cnt_q;
  logic                   accel_hit;

  // The strobe that brings the count to ACCEL_AFTER already picks the fast reload.
  assign accel_hit = (int'(accel_cnt_q) + 1) >= ACCEL_AFTER;
  assign reload    = accel_hit ? FAST_LOAD : PERIOD_LOAD;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accel_cnt_q <= '0;
    end else if (fall || state_q == IDLE) begin
      accel_cnt_q <= '0;
    end else if (expire && accel_cnt_q != '1) begin
      accel_cnt_q <= accel_cnt_q + ACCEL_CNT_W'(1);
    end
  end
`else
  assign reload = PERIOD_LOAD;
`endif

  // Release has priority over a repeat expiry landing on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      adv_q     <= 1'b0;
    end else begin
      adv_q <= 1'b0;
      if (fall) begin
        state_q   <= IDLE;
        rpt_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              adv_q     <= 1'b1;
              rpt_cnt_q <= DELAY_LOAD;
              state_q   <= HELD_DELAY;
            end
          end
          HELD_DELAY, HELD_REPEAT: begin
            if (expire) begin
              adv_q     <= 1'b1;
              rpt_cnt_q <= reload;
              state_q   <= HELD_REPEAT;
            end else begin
              rpt_cnt_q <= rpt_cnt_q - RPT_W'(1);
            end
          end
          default: begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign level_o = level_q;
  assign adv_o   = adv_q;

endmodule

// File: rtl/button_cond.sv
// Push-button conditioner: N_BTN independent debounced levels plus press/auto-repeat strobes.
// Optional fast-sweep acceleration is enabled by defining BUTTON_COND_ACCEL_EN.
module button_cond
  import button_cond_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int DEBOUNCE_CYC  = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
`ifdef BUTTON_COND_ACCEL_EN
  ,
  parameter int ACCEL_AFTER   = 8
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_adv_o
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`ifdef BUTTON_COND_ACCEL_EN
      ,
      .ACCEL_AFTER  (ACCEL_AFTER)
`endif
    ) u_ch (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (btn_raw_i[i]),
      .level_o(btn_level_o[i]),
      .adv_o  (btn_adv_o[i])
    );
  end

endmodule

// File: tb/tb_button_cond.sv
// Directed bench for button_cond: per-cycle level/strobe checks against hand-computed timelines.
module tb_button_cond;
  import button_cond_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] raw = 4'b0000;
  logic [3:0] lvl;
  logic [3:0] adv;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  button_cond #(
    .N_BTN        (4),
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (16),
    .REPEAT_PERIOD(8)
`ifdef BUTTON_COND_ACCEL_EN
    ,
    .ACCEL_AFTER  (2)
`endif
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .btn_raw_i  (raw),
    .btn_level_o(lvl),
    .btn_adv_o  (adv)
  );

  // Strobe cycle bitmaps (bit n set = strobe expected after edge n).
`ifdef BUTTON_COND_ACCEL_EN
  localparam logic [63:0] MAP_HOLD40 = 64'h0000_0444_4040_0040; // 6,22,30,34,38,42
`else
  localparam logic [63:0] MAP_HOLD40 = 64'h0000_0040_4040_0040; // 6,22,30,38
`endif
  localparam logic [63:0] MAP_ONLY6  = 64'h0000_0000_0000_0040; // 6
  localparam logic [63:0] MAP_6_22   = 64'h0000_0000_0040_0040; // 6,22
  localparam logic [63:0] MAP_RSTMID = 64'h0010_0010_0040_0040; // 6,22,36,52

  typedef struct {
    string       name;
    logic [3:0]  mask;
    int          hold;
    int          run;
    int          lvl_on;
    int          lvl_off;
    logic [63:0] adv_map;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int c, input logic [3:0] exp_l,
                       input logic [3:0] exp_a);
    total++;
    if (lvl !== exp_l || adv !== exp_a) begin
      bad++;
      $display("FAIL %s cyc=%0d level=%b adv=%b, required level=%b adv=%b",
               name, c, lvl, adv, exp_l, exp_a);
    end
  endtask

  task automatic do_reset();
    raw   = 4'b0000;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_state", 0, 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] exp_l, exp_a;
    do_reset();
    raw = v.mask;
    for (int c = 1; c <= v.run; c++) begin
      @(posedge clk);
      #1;
      exp_l = (c >= v.lvl_on && c < v.lvl_off) ? v.mask : 4'b0000;
      exp_a = v.adv_map[c] ? v.mask : 4'b0000;
      check(v.name, c, exp_l, exp_a);
      if (c == v.hold) raw = 4'b0000;
    end
  endtask

  initial begin
    vec_t       v;
    logic [3:0] m0;
    logic [3:0] exp_l, exp_a;

    m0 = 4'(1 << BTN_MIN);
    vecs.push_back('{"clean_min",     m0,                          40, 60, 6, 46, MAP_HOLD40});
    vecs.push_back('{"glitch_hrs",    4'(1 << BTN_HRS),             3, 20, 0,  0, 64'h0});
    vecs.push_back('{"min_pulse_tset", 4'(1 << BTN_TSET),           4, 24, 6, 10, MAP_ONLY6});
    vecs.push_back('{"release_min",   m0,                          10, 30, 6, 16, MAP_ONLY6});
    vecs.push_back('{"simul_min_hrs", 4'((1 << BTN_MIN) | (1 << BTN_HRS)), 40, 60, 6, 46, MAP_HOLD40});
    vecs.push_back('{"hold20_aset",   4'(1 << BTN_ASET),           20, 40, 6, 26, MAP_6_22});
`ifdef BUTTON_COND_ACCEL_EN
    vecs.push_back('{"accel_min",     m0,                          60, 63, 6, 66,
                     64'h4444_4444_4040_0040});
`endif

    foreach (vecs[i]) begin
      v = vecs[i];
      run_vec(v);
    end

    // Reset asserted mid-hold with the button still pressed.
    do_reset();
    raw = m0;
    for (int c = 1; c <= 56; c++) begin
      @(posedge clk);
      #1;
      exp_l = ((c >= 6 && c <= 25) || c >= 36) ? m0 : 4'b0000;
      exp_a = MAP_RSTMID[c] ? m0 : 4'b0000;
      check("reset_mid_hold", c, exp_l, exp_a);
      if (c == 25) begin
        rst_n = 1'b0;
        #1;
        check("reset_mid_clear", c, 4'b0000, 4'b0000);
      end
      if (c == 30) rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_cond.md
Name: button_cond

Overview:
- Upstream input conditioner for the alarm-clock core (struct_diag).
- Takes raw mechanical push-buttons (Minadv, Hrsadv, Timeset, Alarmset) and produces:
  - a clean debounced level per button;
  - a single-cycle advance strobe per button, with auto-repeat while the button is held.
- Outputs drive the core's set/advance inputs directly. Holding Minadv sweeps minutes without per-step presses.

Parameters:
- N_BTN, 4: number of independent button channels.
- DEBOUNCE_CYC, 4: consecutive stable synchronized samples required to change a debounced level (≥1).
- REPEAT_DELAY, 16: cycles from the press strobe to the first auto-repeat strobe (≥2).
- REPEAT_PERIOD, 8: cycles between subsequent auto-repeat strobes (≥2).
- ACCEL_AFTER, 8: repeat strobes before acceleration takes effect. Used only with BUTTON_COND_ACCEL_EN.

Ports:
- Clk, in, 1: single system clock; all state is on its rising edge.
- Reset, in, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately; deassertion is synchronous to Clk upstream.
- Btn_raw, in, N_BTN: raw asynchronous button inputs, 1 = pressed.
- Btn_level, out, N_BTN: debounced button level, registered.
- Btn_adv, out, N_BTN: one-cycle advance strobe (press + auto-repeat), registered.

Behaviour:
- Reset (Reset=0), all channels:
  - sync FFs = 0;
  - Btn_level = 0, Btn_adv = 0;
  - counters = 0;
  - FSM = IDLE.
- Synchronizer: 2-FF per channel; sync value = second FF. Raw → sync latency is 2 cycles.
- Debounce, per channel:
  - db_cnt increments each cycle sync ≠ Btn_level.
  - db_cnt clears on any cycle sync = Btn_level.
  - When db_cnt reaches DEBOUNCE_CYC, Btn_level toggles and db_cnt clears.
  - Consequence: a glitch shorter than DEBOUNCE_CYC cycles produces no output change.
- Press latency: raw rise sampled at edge 1 → Btn_level = 1 after edge 2 + DEBOUNCE_CYC.
- FSM per channel: IDLE, HELD_DELAY, HELD_REPEAT.
  - IDLE → HELD_DELAY on the Btn_level 0→1 transition.
    - Btn_adv = 1 in the same cycle Btn_level first reads 1, for exactly one cycle.
    - rpt_cnt is loaded with REPEAT_DELAY−1.
  - HELD_DELAY: rpt_cnt decrements each cycle. At 0 → Btn_adv = 1 for one cycle, rpt_cnt ← REPEAT_PERIOD−1, go to HELD_REPEAT.
  - HELD_REPEAT: rpt_cnt decrements each cycle. At 0 → Btn_adv = 1, reload rpt_cnt.
  - Any state → IDLE on the Btn_level 1→0 transition. rpt_cnt clears; no strobe on release.
  - If the release transition and a repeat expiry occur in the same cycle, release wins: no strobe.
- Resulting strobe times, with press strobe at t0: t0, t0+REPEAT_DELAY, then every REPEAT_PERIOD.
- Counter widths: $clog2 of the parameter + 1. Counters saturate-free; reload happens before overflow.
- Channels are fully independent. Simultaneous presses give simultaneous strobes, with no priority or masking.
- Reset mid-hold:
  - state clears immediately;
  - if the button is still held after Reset deasserts, it is treated as a new press: full sync + debounce, then a press strobe.
- Btn_adv is never asserted while Btn_level = 0.

Optional Feature:
- Macro: BUTTON_COND_ACCEL_EN.
- Defined:
  - each channel counts repeat strobes in a 4-bit saturating counter, cleared on entry to IDLE;
  - once ACCEL_AFTER repeats have fired, the reload value becomes max(REPEAT_PERIOD/2, 1)−1 (fast sweep) until release.
- Undefined: period is constant REPEAT_PERIOD; no accel counter is synthesized.

Decomposition:
- Package button_cond_pkg:
  - typedef enum logic [1:0] {IDLE, HELD_DELAY, HELD_REPEAT} btn_state_t;
  - index constants BTN_MIN=0, BTN_HRS=1, BTN_TSET=2, BTN_ASET=3, so the top level wires channels to the core by name.
- Sub-module btn_channel:
  - contains the synchronizer, debounce counter, FSM and repeat counter for one button;
  - button_cond instantiates N_BTN copies in a generate loop.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY=16, REPEAT_PERIOD=8, ACCEL off unless stated):
- Clean press: raw[0] 0→1 before edge 1, held 40 cycles → Btn_level[0]=1 from cycle 6; Btn_adv[0] pulses at cycles 6, 22, 30, 38; no other pulses.
- Glitch: raw[1] high for 3 cycles, then low → Btn_level[1] and Btn_adv[1] stay 0 throughout.
- Release: press held 10 cycles, then released → exactly one strobe (cycle 6); Btn_level returns to 0 six cycles after the raw fall; no strobe on release.
- Simultaneous: raw[0] and raw[1] rise on the same cycle → identical strobe trains on both bits; raw[2] and raw[3] remain quiet.
- Reset mid-hold: Reset=0 at cycle 25 with raw[0] still high; Reset=1 at cycle 30 → outputs 0 immediately; new press strobe at cycle 36; next repeat at cycle 52.
- ACCEL (BUTTON_COND_ACCEL_EN, ACCEL_AFTER=2): hold 60 cycles → strobes at 6, 22, 30, then every 4 cycles (34, 38, …).
